// File: rtl/chi_inv_iter_if.sv
// chi_inv_iter_if: valid/ready handshake bus carrying the 1600-bit state into and out of chi_inv_iter
interface chi_inv_iter_if;
    logic          in_valid;
    logic          in_ready;
    logic [0:1599] S_in;
    logic          out_valid;
    logic          out_ready;
    logic [0:1599] S_out;
    logic          busy;
    modport master (output in_valid, S_in, out_ready, input in_ready, out_valid, S_out, busy);
    modport slave  (input in_valid, S_in, out_ready, output in_ready, out_valid, S_out, busy);
endinterface

// File: rtl/chi_inv_iter.sv
// chi_inv_iter: iterative inverse of Keccak-f[1600] chi, PLANES_PER_CYCLE y-planes per busy cycle
module chi_inv_iter #(
    parameter int PLANES_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    chi_inv_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [4:0] chi_row(input logic [4:0] a);
        logic [4:0] b;
        for (int x = 0; x < 5; x++) b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
        return b;
    endfunction

    // entry b of the table holds the row a with chi_row(a) == b
    function automatic logic [159:0] build_inv();
        logic [159:0] t;
        t = '0;
        for (int a = 0; a < 32; a++) t[5 * int'(chi_row(5'(a))) +: 5] = 5'(a);
        return t;
    endfunction

    localparam logic [159:0] INV = build_inv();

    if (PLANES_PER_CYCLE != 1 && PLANES_PER_CYCLE != 5) begin : g_bad
        $error("chi_inv_iter: PLANES_PER_CYCLE must be 1 or 5");
    end

    state_t        state, nxt;
    logic [2:0]    cnt;
    logic [0:1599] st, inv;
    logic [4:0]    sel;

    for (genvar y = 0; y < 5; y++) begin : g_y
        for (genvar z = 0; z < 64; z++) begin : g_z
            logic [4:0] r, q;
            for (genvar x = 0; x < 5; x++) begin : g_x
                assign r[x] = st[64 * (5 * y + x) + z];
                assign inv[64 * (5 * y + x) + z] = q[x];
            end
            assign q = INV[5 * int'(r) +: 5];
        end
        assign sel[y] = PLANES_PER_CYCLE == 5 || cnt == 3'(y);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        if (state == IDLE && bus.in_valid) nxt = BUSY;
        if (state == BUSY && cnt == 3'(5 - PLANES_PER_CYCLE)) nxt = DONE;
        if (state == DONE && bus.out_ready) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            st  <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            cnt <= '0;
            st  <= bus.S_in;
        end else if (state == BUSY) begin
            cnt <= cnt + 3'(PLANES_PER_CYCLE);
            for (int p = 0; p < 5; p++) if (sel[p]) st[320 * p +: 320] <= inv[320 * p +: 320];
        end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.S_out     = st;
endmodule

// File: tb/tb_chi_inv_iter.sv
// tb_chi_inv_iter: directed and randomized round-trip checks of chi_inv_iter for PLANES_PER_CYCLE 1 and 5
module tb_chi_inv_iter;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;

    chi_inv_iter_if i1();
    chi_inv_iter_if i5();

    chi_inv_iter #(.PLANES_PER_CYCLE(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    chi_inv_iter #(.PLANES_PER_CYCLE(5)) d5 (.clk(clk), .rst_n(rst_n), .bus(i5));

    always #5 clk = ~clk;

    function automatic logic [0:1599] chi(input logic [0:1599] s);
        logic [0:1599] r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int z = 0; z < 64; z++)
                    r[64 * (5 * y + x) + z] = s[64 * (5 * y + x) + z] ^
                        (~s[64 * (5 * y + (x + 1) % 5) + z] & s[64 * (5 * y + (x + 2) % 5) + z]);
        return r;
    endfunction

    function automatic logic [0:1599] rand_state();
        logic [0:1599] r;
        for (int k = 0; k < 50; k++) r[32 * k +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input int p, input logic v, input logic [0:1599] s, input logic r);
        if (p == 1) begin
            i1.in_valid = v; i1.S_in = s; i1.out_ready = r;
        end else begin
            i5.in_valid = v; i5.S_in = s; i5.out_ready = r;
        end
    endtask

    // {in_ready, out_valid, busy}
    function automatic logic [2:0] flags(input int p);
        return p == 1 ? {i1.in_ready, i1.out_valid, i1.busy} : {i5.in_ready, i5.out_valid, i5.busy};
    endfunction

    function automatic logic [0:1599] sout(input int p);
        return p == 1 ? i1.S_out : i5.S_out;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chk_s(input string tag, input logic [0:1599] o, input logic [0:1599] e);
        int k;
        checks++;
        assert (o === e) else begin
            errors++;
            k = 0;
            while (k < 1599 && o[k] === e[k]) k++;
            $error("FAIL %s: S_out bit %0d observed %b expected %b, %0d bits differ", tag, k, o[k], e[k], $countones(o ^ e));
        end
    endtask

    task automatic wait_out(input int p, output int n);
        logic [2:0] f;
        n = 0;
        f = flags(p);
        while (f[1] !== 1'b1 && n < 20) begin
            tick();
            n++;
            f = flags(p);
        end
    endtask

    task automatic run_job(input int p, input logic [0:1599] s, input logic [0:1599] e, input string tag);
        int n;
        chk({tag, "/idle"}, 32'(flags(p)), 32'b100);
        drive(p, 1, s, 0);
        tick();
        drive(p, 0, '0, 0);
        chk({tag, "/busy"}, 32'(flags(p)), 32'b001);
        wait_out(p, n);
        chk({tag, "/latency"}, n, p == 1 ? 5 : 1);
        chk({tag, "/done"}, 32'(flags(p)), 32'b011);
        chk_s({tag, "/data"}, sout(p), e);
        drive(p, 0, '0, 1);
        tick();
        drive(p, 0, '0, 0);
        chk({tag, "/after"}, 32'(flags(p)), 32'b100);
    endtask

    initial begin
        logic [0:1599] x, s2, e2;
        int n;
        drive(1, 0, '0, 0);
        drive(5, 0, '0, 0);
        tick();
        tick();
        chk("reset/flags1", 32'(flags(1)), 32'b100);
        chk("reset/flags5", 32'(flags(5)), 32'b100);
        chk_s("reset/sout1", sout(1), '0);
        rst_n = 1;
        tick();
        s2 = '0; s2[0] = 1'b1; s2[192] = 1'b1;
        e2 = '0; e2[0] = 1'b1;
        for (int p = 1; p <= 5; p += 4) begin
            run_job(p, '0, '0, "zeros");
            run_job(p, '1, '1, "ones");
            run_job(p, s2, e2, "single_row");
        end
        for (int p = 1; p <= 5; p += 4)
            for (int j = 0; j < 200; j++) begin
                x = rand_state();
                run_job(p, chi(x), x, p == 1 ? "rt1" : "rt5");
            end
        x = rand_state();
        drive(1, 1, chi(x), 0);
        tick();
        drive(1, 0, '0, 0);
        wait_out(1, n);
        chk("bp/latency", n, 5);
        for (int k = 0; k < 10; k++) begin
            drive(1, k[0], rand_state(), 0);
            tick();
            chk("bp/flags", 32'(flags(1)), 32'b011);
            chk_s("bp/data", sout(1), x);
        end
        drive(1, 1, rand_state(), 1);
        tick();
        drive(1, 0, '0, 0);
        chk("bp/both_high", 32'(flags(1)), 32'b100);
        x = rand_state();
        run_job(1, chi(x), x, "bp/next");
        x = rand_state();
        drive(1, 1, chi(x), 0);
        tick();
        drive(1, 0, '0, 0);
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("rst/flags", 32'(flags(1)), 32'b100);
        chk_s("rst/sout", sout(1), '0);
        tick();
        chk("rst/held", 32'(flags(1)), 32'b100);
        rst_n = 1;
        tick();
        chk("rst/no_pulse", 32'(flags(1)), 32'b100);
        x = rand_state();
        run_job(1, chi(x), x, "rst/next");
        for (int j = 0; j < 4; j++) begin
            x = rand_state();
            chk("b2b/ready", 32'(flags(1)), 32'b100);
            drive(1, 1, chi(x), 1);
            tick();
            drive(1, 0, '0, 1);
            wait_out(1, n);
            chk("b2b/latency", n, 5);
            chk_s("b2b/data", sout(1), x);
            tick();
            chk("b2b/after", 32'(flags(1)), 32'b100);
        end
        drive(1, 0, '0, 0);
        tick();
        chk("b2b/no_dup", 32'(flags(1)), 32'b100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
